// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_STALL  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it and wins over push/pop.
module fetch_buffer import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        push_entry,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, prefetch buffer, redirect/halt control.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stalls counters.
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [1:0]  fetch_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  // Handshake: an entry transfers on a rising edge where instr_valid && instr_ready;
  // instr/instr_pc are held stable while instr_valid is high and instr_ready is low.

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_after;
  logic          push, deq, flush;
  entry_t        head;
  entry_t        push_entry;
  logic          unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign deq         = instr_valid && instr_ready;
  assign push_entry  = '{pc: pc_q, instr: imem_data};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    cnt_after = count;
    if (redirect_valid) begin
      // Redirect beats halt and any pending dequeue; the flush empties everything.
      flush   = 1'b1;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            push      = (count < CW'(BUF_DEPTH)) || deq;
            cnt_after = count + CW'(push) - CW'(deq);
            if ((cnt_after == CW'(BUF_DEPTH)) && !deq) begin
              state_d = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (deq) begin
            state_d = ST_FETCH;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
      if (push) begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (deq),
    .flush      (flush),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign imem_addr   = pc_q;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_valid = (count != '0);
  assign fetch_state = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(push);
    perf_stalls_d  = perf_stalls_q + 32'(state_q == ST_STALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; instruction memory returns its own address.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  int n_tests;
  int n_fail;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_state    (fetch_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls)
`endif
  );

  assign imem_data = imem_addr;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    instr_ready    = ready;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    #1;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
    n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    n_tests++; if (fetch_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fetch_state); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_pre_valid: got %b expected 0", instr_valid); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, instr_valid); end
      n_tests++; if (instr_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, instr_pc, 32'(4 * i)); end
      n_tests++; if (instr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, instr, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    step();
    n_tests++; if (fetch_state !== 2'd0) begin n_fail++; $display("FAIL stall_state1: got %0d expected 0", fetch_state); end
    n_tests++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_addr1: got %h expected 4", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (fetch_state !== 2'd1) begin n_fail++; $display("FAIL stall_state[%0d]: got %0d expected 1", i, fetch_state); end
      n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 8", i, imem_addr); end
      n_tests++; if (instr_pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc %h instr %h v %b expected 0 0 1", i, instr_pc, instr, instr_valid); end
    end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_fetched !== 32'd2) begin n_fail++; $display("FAIL perf_fetched: got %0d expected 2", perf_fetched); end
    n_tests++; if (perf_stalls !== 32'd3) begin n_fail++; $display("FAIL perf_stalls: got %0d expected 3", perf_stalls); end
`endif
    instr_ready = 1'b1;
    step();
    n_tests++; if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL unstall_pc: got %h expected 4", instr_pc); end
    n_tests++; if (fetch_state !== 2'd0) begin n_fail++; $display("FAIL unstall_state: got %0d expected 0", fetch_state); end
    n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL unstall_nopush: got %h expected 8", imem_addr); end
    step();
    n_tests++; if (instr_pc !== 32'h8) begin n_fail++; $display("FAIL unstall_pc2: got %h expected 8", instr_pc); end
    n_tests++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL unstall_addr2: got %h expected c", imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    repeat (4) step();
    n_tests++; if (imem_addr !== 32'h10 || instr_pc !== 32'hC) begin n_fail++; $display("FAIL redir_setup: got addr %h pc %h expected 10 c", imem_addr, instr_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    n_tests++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %h expected 40", imem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", instr_valid); end
    step();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h40) begin n_fail++; $display("FAIL redir_first: got v %b pc %h instr %h expected 1 40 40", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    repeat (7) step();
    n_tests++; if (imem_addr !== 32'h1C || instr_pc !== 32'h18) begin n_fail++; $display("FAIL halt_setup: got addr %h pc %h expected 1c 18", imem_addr, instr_pc); end
    instr_ready = 1'b0;
    step();
    n_tests++; if (imem_addr !== 32'h20 || fetch_state !== 2'd1) begin n_fail++; $display("FAIL halt_fill: got addr %h st %0d expected 20 1", imem_addr, fetch_state); end
    halt = 1'b1;
    instr_ready = 1'b1;
    step();
    halt = 1'b0;
    n_tests++; if (fetch_state !== 2'd2) begin n_fail++; $display("FAIL halt_state: got %0d expected 2", fetch_state); end
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1C) begin n_fail++; $display("FAIL halt_drain1: got v %b pc %h expected 1 1c", instr_valid, instr_pc); end
    n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL halt_addr1: got %h expected 20", imem_addr); end
    step();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain2: got %b expected 0", instr_valid); end
    repeat (3) step();
    n_tests++; if (fetch_state !== 2'd2 || imem_addr !== 32'h20 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got st %0d addr %h v %b expected 2 20 0", fetch_state, imem_addr, instr_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_tests++; if (fetch_state !== 2'd0 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL halt_resume: got st %0d addr %h expected 0 100", fetch_state, imem_addr); end
    step();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin n_fail++; $display("FAIL halt_first: got v %b pc %h expected 1 100", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    n_tests++; if (imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr: got %h expected fffffff8", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got v %b pc %h expected 1 %h", i, instr_valid, instr_pc, exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_halt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    halt           = 1'b1;
    step();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    n_tests++; if (fetch_state !== 2'd0 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_halt: got st %0d addr %h v %b expected 0 200 0", fetch_state, imem_addr, instr_valid); end
    step();
    n_tests++; if (instr_pc !== 32'h200 || imem_addr !== 32'h204) begin n_fail++; $display("FAIL redir_halt_run: got pc %h addr %h expected 200 204", instr_pc, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    repeat (3) step();
    n_tests++; if (fetch_state !== 2'd1) begin n_fail++; $display("FAIL rmid_setup: got %0d expected 1", fetch_state); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (instr_valid !== 1'b0 || fetch_state !== 2'd0) begin n_fail++; $display("FAIL rmid_async: got v %b st %0d expected 0 0", instr_valid, fetch_state); end
    n_tests++; if (imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_clear: got addr %h instr %h pc %h expected 0 0 0", imem_addr, instr, instr_pc); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_fetched !== 32'd0 || perf_stalls !== 32'd0) begin n_fail++; $display("FAIL rmid_perf: got %0d %0d expected 0 0", perf_fetched, perf_stalls); end
`endif
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    step();
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rmid_restart: got v %b pc %h addr %h expected 1 0 4", instr_valid, instr_pc, imem_addr); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_redirect_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
